video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: front porch, sync width and back porch in pixels; H_TOT = sum of the four.
REQ-003 The block SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: the same quantities in lines; V_TOT = sum of the four.
REQ-004 The block SHALL have parameters HS_POL 0 and VS_POL 0: asserted sync level (0 = active low).
REQ-005 The block SHALL have parameters X_SHL 0 (DrawX left shift), Y_SHR 0 (DrawY right shift), PREFETCH 2 (lookahead pixels, 0..H_ACTIVE) and CW 11 (coordinate width).
REQ-006 dclk  input  1  clock, all logic rising-edge.
REQ-007 Reset  input  1  reset, synchronous, active-high.
REQ-008 pix_ce  input  1  pixel clock enable; the position advances only on dclk edges with pix_ce=1.
REQ-009 hs, vs  output  1 each  horizontal and vertical sync, level per HS_POL/VS_POL.
REQ-010 blank  output  1  active-low blanking; 1 inside the visible region.
REQ-011 sync  output  1  composite sync, driven constant 0.
REQ-012 DrawX, DrawY  output  CW each  scaled pixel coordinates.
REQ-013 line_start, frame_start, vblank_start  output  1 each  single-cycle event pulses.
REQ-014 prefetch_valid  output  1; prefetch_x  output  CW  lookahead fetch request.
REQ-015 frame_cnt  output  8  completed-frame counter.

Function
REQ-016 Internal position: h in 0..H_TOT-1, v in 0..V_TOT-1; on pix_ce, h increments; at h=H_TOT-1, h wraps to 0 and v increments; at v=V_TOT-1 with that wrap, v wraps to 0.
REQ-017 All outputs SHALL be registered and SHALL update on the same edge as the position, decoding the new (h,v): zero latency between position and outputs.
REQ-018 hs SHALL equal HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; vs SHALL equal VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL; vs is decoded on v only.
REQ-019 blank SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-020 DrawX SHALL be (h<<X_SHL) and DrawY SHALL be (v>>Y_SHR), both truncated to CW bits.
REQ-021 line_start SHALL be 1 when the new h=0; frame_start when the new (h,v)=(0,0); vblank_start when the new (h,v)=(0,V_ACTIVE).
REQ-022 Each pulse SHALL last exactly one dclk cycle and SHALL drop on the next edge even when pix_ce=0.
REQ-023 prefetch_x SHALL be h+PREFETCH; prefetch_valid SHALL be 1 iff h+PREFETCH<H_ACTIVE and v<V_ACTIVE; it SHALL never anticipate the next line.
REQ-024 PREFETCH=0 SHALL make prefetch_valid identical to blank.
REQ-025 frame_cnt SHALL increment, modulo 256, on each wrap to (0,0) except the first one after reset.
REQ-026 pix_ce=0 SHALL hold position, levels, DrawX/DrawY, prefetch outputs and frame_cnt unchanged.
REQ-027 Elaboration SHALL fail if H_TOT or V_TOT exceeds 2^CW, or if PREFETCH>H_ACTIVE.

Reset
REQ-028 Reset SHALL set the position to (H_TOT-1,V_TOT-1) and SHALL set hs=~HS_POL, vs=~VS_POL, blank=0, all pulses 0, DrawX=DrawY=0, prefetch_valid=0, prefetch_x=0, frame_cnt=0.
REQ-029 Reset SHALL override pix_ce in the same cycle; Reset asserted mid-frame SHALL abort the frame with no pulses emitted.
REQ-030 The first pix_ce edge after reset SHALL produce (0,0) with blank=1 and line_start=frame_start=1; frame_cnt stays 0.

Verification
REQ-031 Defaults, pix_ce=1, Reset released -> frame_start at first edge; next frame_start 420000 cycles later; frame_cnt=1.
REQ-032 Defaults -> hs low for h 656..751 (96 cycles per line); vs low for v 490..491; blank=0 at h=640 and v=480; vblank_start once per frame at (0,480).
REQ-033 pix_ce toggled 1/0 (every other cycle) -> every output held through ce=0 cycles; pulses are 1 cycle wide; frame period 840000 cycles.
REQ-034 H_ACTIVE=256, X_SHL=1, PREFETCH=2 -> DrawX=2h; prefetch_valid drops at h=254 while blank stays 1 until h=256.
REQ-035 Reset asserted at (300,200) with pix_ce=1 -> next cycle idle values per REQ-028; first ce then gives (0,0) with frame_start and frame_cnt=0.
REQ-036 Run 256 frames -> frame_cnt wraps 255->0 without affecting timing.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator. Walks a pixel position (h, v) across an
//   H_TOT x V_TOT raster, one step per dclk edge with pix_ce high. Every
//   output is registered from the *next* position, so each output always
//   describes the position that is current in that cycle.
//
// Ports
//   dclk           clock, rising edge
//   Reset          synchronous, active-high; parks at (H_TOT-1, V_TOT-1)
//   pix_ce         pixel clock enable
//   hs, vs         horizontal / vertical sync, asserted level HS_POL / VS_POL
//   blank          1 inside the visible region
//   sync           composite sync, constant 0
//   DrawX, DrawY   scaled pixel coordinates (h << X_SHL, v >> Y_SHR)
//   line_start     one-cycle pulse when a line begins (h = 0)
//   frame_start    one-cycle pulse at (0, 0)
//   vblank_start   one-cycle pulse at (0, V_ACTIVE)
//   prefetch_valid lookahead pixel h+PREFETCH lies on the current visible line
//   prefetch_x     lookahead pixel h+PREFETCH
//   frame_cnt      completed-frame counter, mod 256
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned X_SHL    = 0,
  parameter int unsigned Y_SHR    = 0,
  parameter int unsigned PREFETCH = 2,
  parameter int unsigned CW       = 11
) (
  input  logic          dclk,
  input  logic          Reset,
  input  logic          pix_ce,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start,
  output logic          prefetch_valid,
  output logic [CW-1:0] prefetch_x,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOT - 1);
  localparam logic [CW-1:0] V_VBLNK = CW'(V_ACTIVE);

  if (longint'(H_TOT) > (longint'(1) << CW)) begin : g_bad_htot
    $error("video_timing_gen: H_TOT does not fit in CW bits");
  end
  if (longint'(V_TOT) > (longint'(1) << CW)) begin : g_bad_vtot
    $error("video_timing_gen: V_TOT does not fit in CW bits");
  end
  if (PREFETCH > H_ACTIVE) begin : g_bad_prefetch
    $error("video_timing_gen: PREFETCH exceeds H_ACTIVE");
  end

  logic [CW-1:0] h, v;
  logic [CW-1:0] h_n, v_n;
  logic [31:0]   hx, vx, px;
  logic          hs_n, vs_n, blank_n, pv_n, origin_n;
  logic          first_seen;

  assign sync = 1'b0;

  // Decode the position that the next enabled edge will move to, so the
  // registered outputs line up with the position register.
  always_comb begin
    h_n = h + 1'b1;
    v_n = v;
    if (h == H_LAST) begin
      h_n = '0;
      v_n = (v == V_LAST) ? '0 : v + 1'b1;
    end
    hx       = 32'(h_n);
    vx       = 32'(v_n);
    px       = hx + PREFETCH;
    hs_n     = (hx >= HS_START && hx < HS_END) ? HS_POL : ~HS_POL;
    vs_n     = (vx >= VS_START && vx < VS_END) ? VS_POL : ~VS_POL;
    blank_n  = (hx < H_ACTIVE) && (vx < V_ACTIVE);
    pv_n     = (px < H_ACTIVE) && (vx < V_ACTIVE);
    origin_n = (h_n == '0) && (v_n == '0);
  end

  always_ff @(posedge dclk) begin
    if (Reset) begin
      h              <= H_LAST;
      v              <= V_LAST;
      hs             <= ~HS_POL;
      vs             <= ~VS_POL;
      blank          <= 1'b0;
      DrawX          <= '0;
      DrawY          <= '0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      vblank_start   <= 1'b0;
      prefetch_valid <= 1'b0;
      prefetch_x     <= '0;
      frame_cnt      <= '0;
      first_seen     <= 1'b0;
    end else begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      if (pix_ce) begin
        h              <= h_n;
        v              <= v_n;
        hs             <= hs_n;
        vs             <= vs_n;
        blank          <= blank_n;
        DrawX          <= h_n << X_SHL;
        DrawY          <= v_n >> Y_SHR;
        prefetch_valid <= pv_n;
        prefetch_x     <= CW'(px);
        line_start     <= (h_n == '0);
        frame_start    <= origin_n;
        vblank_start   <= (h_n == '0) && (v_n == V_VBLNK);
        // The first arrival at the origin after reset starts frame 0
        // rather than completing one.
        if (origin_n) begin
          first_seen <= 1'b1;
          if (first_seen) frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Bench for video_timing_gen on a small raster (10 x 7) so that hundreds
//   of frames fit in a short run. Expected outputs come from a raster model
//   that tracks the position as plain integers and applies the timing rules.
module tb_video_timing_gen;

  localparam int HA = 6, HF = 1, HSY = 2, HB = 1;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam bit HSP = 1'b1, VSP = 1'b0;
  localparam int XS = 1, YS = 1, PF = 2, CW = 4;

  logic          dclk = 1'b0;
  logic          Reset = 1'b1;
  logic          pix_ce = 1'b0;
  logic          hs, vs, blank, sync;
  logic [CW-1:0] DrawX, DrawY, prefetch_x;
  logic          line_start, frame_start, vblank_start, prefetch_valid;
  logic [7:0]    frame_cnt;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP),
    .X_SHL(XS), .Y_SHR(YS), .PREFETCH(PF), .CW(CW)
  ) dut (
    .dclk(dclk), .Reset(Reset), .pix_ce(pix_ce),
    .hs(hs), .vs(vs), .blank(blank), .sync(sync),
    .DrawX(DrawX), .DrawY(DrawY),
    .line_start(line_start), .frame_start(frame_start), .vblank_start(vblank_start),
    .prefetch_valid(prefetch_valid), .prefetch_x(prefetch_x),
    .frame_cnt(frame_cnt)
  );

  always #5 dclk = ~dclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int mh, mv, fcnt;
  bit started;
  bit e_hs, e_vs, e_blank, e_ls, e_fs, e_vbs, e_pv;
  int e_dx, e_dy, e_px;

  int cyc = 0;
  int last_fs = -1;
  int exp_period = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit ce);
    if (rst) begin
      mh = HT - 1; mv = VT - 1;
      e_hs = !HSP; e_vs = !VSP; e_blank = 0;
      e_ls = 0; e_fs = 0; e_vbs = 0;
      e_dx = 0; e_dy = 0; e_pv = 0; e_px = 0;
      fcnt = 0; started = 0;
    end else begin
      e_ls = 0; e_fs = 0; e_vbs = 0;
      if (ce) begin
        mh = (mh + 1) % HT;
        if (mh == 0) mv = (mv + 1) % VT;
        e_hs    = (mh >= HA + HF && mh < HA + HF + HSY) ? HSP : !HSP;
        e_vs    = (mv >= VA + VF && mv < VA + VF + VSY) ? VSP : !VSP;
        e_blank = (mh < HA) && (mv < VA);
        e_dx    = (mh * (1 << XS)) % (1 << CW);
        e_dy    = (mv / (1 << YS)) % (1 << CW);
        e_px    = (mh + PF) % (1 << CW);
        e_pv    = (mh + PF < HA) && (mv < VA);
        e_ls    = (mh == 0);
        e_fs    = (mh == 0) && (mv == 0);
        e_vbs   = (mh == 0) && (mv == VA);
        if (e_fs) begin
          if (started) fcnt = (fcnt + 1) % 256;
          started = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("hs", hs, e_hs);
    chk("vs", vs, e_vs);
    chk("blank", blank, e_blank);
    chk("sync", sync, 0);
    chk("DrawX", DrawX, e_dx);
    chk("DrawY", DrawY, e_dy);
    chk("line_start", line_start, e_ls);
    chk("frame_start", frame_start, e_fs);
    chk("vblank_start", vblank_start, e_vbs);
    chk("prefetch_valid", prefetch_valid, e_pv);
    chk("prefetch_x", prefetch_x, e_px);
    chk("frame_cnt", frame_cnt, fcnt);
  endtask

  // One clock: drive inputs, advance the model on the edge, check 1ns later.
  task automatic step(input bit rst, input bit ce);
    Reset = rst;
    pix_ce = ce;
    @(posedge dclk);
    model_edge(rst, ce);
    #1;
    cyc++;
    check_all();
    if (rst) last_fs = -1;
    else if (frame_start === 1'b1) begin
      if (exp_period != 0 && last_fs >= 0) chk("frame_period", cyc - last_fs, exp_period);
      last_fs = cyc;
    end
  endtask

  int wraps = 0;
  logic [7:0] prev_fc;
  bit found;

  initial begin
    // Reset held, pix_ce both low and high: idle values
    step(1, 0);
    step(1, 1);
    step(1, 0);

    // First enabled edge after reset lands on the origin
    step(0, 1);
    chk("first_frame_start", frame_start, 1);
    chk("first_line_start", line_start, 1);
    chk("first_blank", blank, 1);
    chk("first_frame_cnt", frame_cnt, 0);

    // Continuous enable: period HT*VT
    exp_period = HT * VT;
    last_fs = cyc;
    repeat (2 * HT * VT) step(0, 1);

    // Alternating enable: period doubles, holds checked every cycle
    exp_period = 2 * HT * VT;
    last_fs = -1;
    for (int i = 0; i < 4 * HT * VT + 4; i++) step(0, i[0]);

    // Random enable with occasional resets
    exp_period = 0;
    last_fs = -1;
    for (int i = 0; i < 4 * HT * VT; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0);

    // Mid-frame reset with pix_ce high
    found = 0;
    for (int i = 0; i < 4 * HT * VT && !found; i++) begin
      step(0, 1);
      if (mh == 5 && mv == 2) found = 1;
    end
    chk("reach_mid_frame", found, 1);
    step(1, 1);
    chk("abort_frame_start", frame_start, 0);
    chk("abort_blank", blank, 0);
    step(0, 1);
    chk("restart_frame_start", frame_start, 1);
    chk("restart_frame_cnt", frame_cnt, 0);

    // 258 frames: frame_cnt wraps 255 -> 0 while period stays HT*VT
    exp_period = HT * VT;
    last_fs = cyc;
    for (int i = 0; i < 258 * HT * VT; i++) begin
      prev_fc = frame_cnt;
      step(0, 1);
      if (frame_start === 1'b1 && prev_fc == 8'd255 && frame_cnt == 8'd0) wraps++;
    end
    chk("frame_cnt_wraps", wraps, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
